// File: rtl/inverse_sequencer.sv
// Arbitrates two requesters onto the shared GF(2^m) inverter: loads the operand,
// issues the inverse command, waits a fixed latency and returns the result.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for a request; round-robin grant, operand latched
// WRITE   | operand written to the inverter register file
// CMD     | inverse command pulsed, wait counter loaded
// WAIT    | counting down the inverter latency
// CAPTURE | inverter result sampled into rsp_data
// ZERO    | zero operand: error response, inverter left untouched
// RESP    | rsp_valid held to the owner until it accepts
//
// Every output is a register written on the edge that leaves the state that
// owns it, so each output appears one cycle after its state is entered.
module inverse_sequencer #(
    parameter logic [5:0]  OPERAND_ADDR = 6'h04,
    parameter logic [5:0]  CMD_INVERSE  = 6'h01,
    parameter int unsigned INV_LATENCY  = 260,
    parameter int unsigned CNT_W        = 9,
    parameter logic [63:0] POLY         = 64'h0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [255:0] op0,
    input  logic [255:0] op1,
    output logic [1:0]   rsp_valid,
    input  logic [1:0]   rsp_ready,
    output logic [255:0] rsp_data,
    output logic         rsp_err,
    output logic         busy,
    output logic         inv_wr_en,
    output logic [5:0]   inv_addr,
    output logic [255:0] inv_wdata,
    output logic [5:0]   inv_command,
    output logic [63:0]  inv_poly,
    input  logic [255:0] inv_rdata
);

    typedef enum logic [2:0] {
        IDLE, WRITE, CMD, WAIT, CAPTURE, ZERO, RESP
    } state_t;

    state_t             r_state;
    logic               r_owner;
    logic               r_last_grant;
    logic [255:0]       r_op_q;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_req_ready;
    logic [1:0]         r_rsp_valid;
    logic [255:0]       r_rsp_data;
    logic               r_rsp_err;
    logic               r_busy;
    logic               r_inv_wr_en;
    logic [5:0]         r_inv_addr;
    logic [255:0]       r_inv_wdata;
    logic [5:0]         r_inv_command;

    logic               w_grant;
    logic               w_grant_idx;
    logic [255:0]       w_grant_op;
    logic               w_op_zero;
    logic               w_rsp_ack;

    // On a tie the requester that did not win last time is served.
    assign w_grant     = |req_valid;
    assign w_grant_idx = (&req_valid) ? ~r_last_grant : req_valid[1];
    assign w_grant_op  = w_grant_idx ? op1 : op0;
    assign w_op_zero   = (w_grant_op == 256'd0);
    assign w_rsp_ack   = r_rsp_valid[r_owner] & rsp_ready[r_owner];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_owner       <= 1'b0;
            r_last_grant  <= 1'b1;
            r_op_q        <= '0;
            r_cnt         <= '0;
            r_req_ready   <= '0;
            r_rsp_valid   <= '0;
            r_rsp_data    <= '0;
            r_rsp_err     <= 1'b0;
            r_busy        <= 1'b0;
            r_inv_wr_en   <= 1'b0;
            r_inv_addr    <= '0;
            r_inv_wdata   <= '0;
            r_inv_command <= '0;
        end else begin
            r_req_ready   <= '0;
            r_inv_wr_en   <= 1'b0;
            r_inv_addr    <= '0;
            r_inv_wdata   <= '0;
            r_inv_command <= '0;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_owner     <= w_grant_idx;
                        r_op_q      <= w_grant_op;
                        r_req_ready <= w_grant_idx ? 2'b10 : 2'b01;
                        r_busy      <= 1'b1;
                        r_state     <= w_op_zero ? ZERO : WRITE;
                    end
                end
                WRITE: begin
                    r_inv_wr_en <= 1'b1;
                    r_inv_addr  <= OPERAND_ADDR;
                    r_inv_wdata <= r_op_q;
                    r_state     <= CMD;
                end
                CMD: begin
                    r_inv_command <= CMD_INVERSE;
                    r_cnt         <= CNT_W'(INV_LATENCY - 1);
                    r_state       <= WAIT;
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= CAPTURE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                CAPTURE: begin
                    r_rsp_data <= inv_rdata;
                    r_rsp_err  <= 1'b0;
                    r_state    <= RESP;
                end
                ZERO: begin
                    r_rsp_data <= '0;
                    r_rsp_err  <= 1'b1;
                    r_state    <= RESP;
                end
                RESP: begin
                    // rsp_ready only counts once rsp_valid is actually visible.
                    if (r_rsp_valid == 2'b00) begin
                        r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
                    end else if (w_rsp_ack) begin
                        r_rsp_valid  <= '0;
                        r_last_grant <= r_owner;
                        r_busy       <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_err     = r_rsp_err;
    assign busy        = r_busy;
    assign inv_wr_en   = r_inv_wr_en;
    assign inv_addr    = r_inv_addr;
    assign inv_wdata   = r_inv_wdata;
    assign inv_command = r_inv_command;
    assign inv_poly    = POLY;

endmodule

// File: tb/tb_inverse_sequencer.sv
// Bench for inverse_sequencer: a latency-8 and a latency-1 instance, each with a
// strict-window inverter model; table-driven transactions plus a mid-WAIT reset.
module tb_inverse_sequencer;

    localparam int LAT_A = 8;
    localparam int LAT_B = 1;
    localparam logic [255:0] GARBAGE = 256'hDEAD_BEEF_0BAD_F00D;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         sel;
    logic [1:0]   t_req_valid, t_rsp_ready;
    logic [255:0] t_op0, t_op1;

    logic [1:0]   a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready;
    logic [255:0] a_rsp_data, a_inv_wdata, a_inv_rdata;
    logic         a_rsp_err, a_busy, a_inv_wr_en;
    logic [5:0]   a_inv_addr, a_inv_command;
    logic [63:0]  a_inv_poly;

    logic [1:0]   b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
    logic [255:0] b_rsp_data, b_inv_wdata, b_inv_rdata;
    logic         b_rsp_err, b_busy, b_inv_wr_en;
    logic [5:0]   b_inv_addr, b_inv_command;
    logic [63:0]  b_inv_poly;

    assign a_req_valid = sel ? 2'b00 : t_req_valid;
    assign a_rsp_ready = sel ? 2'b00 : t_rsp_ready;
    assign b_req_valid = sel ? t_req_valid : 2'b00;
    assign b_rsp_ready = sel ? t_rsp_ready : 2'b00;

    inverse_sequencer #(.INV_LATENCY(LAT_A), .CNT_W(9)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .op0(t_op0), .op1(t_op1), .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_data(a_rsp_data), .rsp_err(a_rsp_err), .busy(a_busy),
        .inv_wr_en(a_inv_wr_en), .inv_addr(a_inv_addr), .inv_wdata(a_inv_wdata),
        .inv_command(a_inv_command), .inv_poly(a_inv_poly), .inv_rdata(a_inv_rdata)
    );

    inverse_sequencer #(.INV_LATENCY(LAT_B), .CNT_W(9)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .op0(t_op0), .op1(t_op1), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_data(b_rsp_data), .rsp_err(b_rsp_err), .busy(b_busy),
        .inv_wr_en(b_inv_wr_en), .inv_addr(b_inv_addr), .inv_wdata(b_inv_wdata),
        .inv_command(b_inv_command), .inv_poly(b_inv_poly), .inv_rdata(b_inv_rdata)
    );

    logic [1:0]   w_req_ready, w_rsp_valid;
    logic [255:0] w_rsp_data, w_inv_wdata;
    logic         w_rsp_err, w_busy, w_inv_wr_en;
    logic [5:0]   w_inv_addr, w_inv_command;

    assign w_req_ready   = sel ? b_req_ready   : a_req_ready;
    assign w_rsp_valid   = sel ? b_rsp_valid   : a_rsp_valid;
    assign w_rsp_data    = sel ? b_rsp_data    : a_rsp_data;
    assign w_rsp_err     = sel ? b_rsp_err     : a_rsp_err;
    assign w_busy        = sel ? b_busy        : a_busy;
    assign w_inv_wr_en   = sel ? b_inv_wr_en   : a_inv_wr_en;
    assign w_inv_addr    = sel ? b_inv_addr    : a_inv_addr;
    assign w_inv_wdata   = sel ? b_inv_wdata   : a_inv_wdata;
    assign w_inv_command = sel ? b_inv_command : a_inv_command;

    // Inverter model: result is valid only in the single cycle INV_LATENCY after
    // the command pulse, so any early or late capture returns GARBAGE.
    function automatic logic [255:0] inv_model(input logic [255:0] x);
        return x ^ 256'hB9F9;
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [255:0] a_wq = '0, b_wq = '0;
    int a_cmd_cyc = -1000, b_cmd_cyc = -1000;
    always @(posedge clk) begin
        if (a_inv_wr_en) a_wq <= a_inv_wdata;
        if (a_inv_command == 6'h01) a_cmd_cyc <= cyc;
        if (b_inv_wr_en) b_wq <= b_inv_wdata;
        if (b_inv_command == 6'h01) b_cmd_cyc <= cyc;
    end
    assign a_inv_rdata = (cyc == a_cmd_cyc + LAT_A) ? inv_model(a_wq) : GARBAGE;
    assign b_inv_rdata = (cyc == b_cmd_cyc + LAT_B) ? inv_model(b_wq) : GARBAGE;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic         sel;
        logic [1:0]   rv;
        logic [255:0] op0;
        logic [255:0] op1;
        int           owner;
        logic         err;
        logic [255:0] data;
        int           bp;
        bit           hold;
        bit           early;
    } vec_t;

    task automatic run_txn(input vec_t v, input string tag, output int acc_wait);
        int lat, t_acc, n_wr, n_cmd, unstable, extra;
        bit got;
        logic [1:0] own_bit;
        logic [255:0] exp_op;
        lat      = v.sel ? LAT_B : LAT_A;
        own_bit  = (v.owner == 1) ? 2'b10 : 2'b01;
        exp_op   = (v.owner == 1) ? v.op1 : v.op0;
        sel      = v.sel;
        t_req_valid = v.rv;
        t_op0    = v.op0;
        t_op1    = v.op1;
        got      = 0;
        acc_wait = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            acc_wait++;
            if (w_req_ready != 2'b00) begin got = 1; break; end
        end
        if (!got) begin
            n_vec++; n_err++;
            $display("FAIL %s_accept: no req_ready within 20 cycles", tag);
            return;
        end
        t_acc = cyc;
        chk({tag, "_req_ready"}, w_req_ready, own_bit);
        chk({tag, "_busy_acc"}, w_busy, 1'b1);
        if (!v.hold) t_req_valid = 2'b00;
        if (v.early) t_rsp_ready = own_bit;
        t_op0 = ~v.op0;
        t_op1 = ~v.op1;
        n_wr = 0; n_cmd = 0; extra = 0; got = 0;
        for (int i = 0; i < lat + 20; i++) begin
            @(negedge clk);
            if (w_req_ready != 2'b00) extra++;
            if (w_inv_wr_en) begin
                n_wr++;
                chk({tag, "_wr_cycle"}, cyc - t_acc, 1);
                chk({tag, "_wr_addr"}, w_inv_addr, 6'h04);
                chk({tag, "_wr_data"}, w_inv_wdata, exp_op);
            end
            if (w_inv_command != 6'h00) begin
                n_cmd++;
                chk({tag, "_cmd_cycle"}, cyc - t_acc, 2);
                chk({tag, "_cmd_code"}, w_inv_command, 6'h01);
            end
            if (w_rsp_valid != 2'b00) begin got = 1; break; end
        end
        chk({tag, "_wr_count"}, n_wr, v.err ? 0 : 1);
        chk({tag, "_cmd_count"}, n_cmd, v.err ? 0 : 1);
        if (!got) begin
            n_vec++; n_err++;
            $display("FAIL %s_rsp: no rsp_valid within %0d cycles", tag, lat + 20);
            return;
        end
        chk({tag, "_latency"}, cyc - t_acc, v.err ? 2 : 4 + lat);
        chk({tag, "_rsp_valid"}, w_rsp_valid, own_bit);
        chk({tag, "_rsp_data"}, w_rsp_data, v.data);
        chk({tag, "_rsp_err"}, w_rsp_err, v.err);
        if (v.bp > 0) begin
            unstable = 0;
            t_req_valid = 2'b11;
            t_rsp_ready = ~own_bit;
            for (int i = 0; i < v.bp; i++) begin
                @(negedge clk);
                if (w_rsp_valid !== own_bit || w_rsp_data !== v.data || w_rsp_err !== v.err)
                    unstable++;
                if (w_req_ready != 2'b00) extra++;
            end
            chk({tag, "_bp_unstable"}, unstable, 0);
        end
        chk({tag, "_no_extra_ready"}, extra, 0);
        t_rsp_ready = own_bit;
        t_req_valid = v.hold ? v.rv : 2'b00;
        @(negedge clk);
        t_rsp_ready = 2'b00;
        chk({tag, "_rsp_drop"}, w_rsp_valid, 2'b00);
        chk({tag, "_busy_idle"}, w_busy, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, w_req_ready, 2'b00);
        chk({tag, "_rsp_valid"}, w_rsp_valid, 2'b00);
        chk({tag, "_rsp_data"}, w_rsp_data, 256'd0);
        chk({tag, "_rsp_err"}, w_rsp_err, 1'b0);
        chk({tag, "_busy"}, w_busy, 1'b0);
        chk({tag, "_wr_en"}, w_inv_wr_en, 1'b0);
        chk({tag, "_addr"}, w_inv_addr, 6'h00);
        chk({tag, "_wdata"}, w_inv_wdata, 256'd0);
        chk({tag, "_command"}, w_inv_command, 6'h00);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs[10];
    vec_t vr;
    int   wcnt;
    int   t_acc;
    bit   got;

    initial begin
        logic [255:0] top_bit;
        top_bit = 256'd1 << 255;
        //        sel   rv     op0          op1          own err  data                 bp  hold early
        vecs[0] = '{1'b0, 2'b01, 256'h1234,   256'h9999,   0, 1'b0, 256'hABCD,           0, 0, 0};
        vecs[1] = '{1'b0, 2'b10, 256'h4444,   256'h0,      1, 1'b1, 256'h0,              0, 0, 1};
        vecs[2] = '{1'b0, 2'b11, 256'h5555,   256'h7777,   0, 1'b0, 256'hECAC,           0, 1, 1};
        vecs[3] = '{1'b0, 2'b11, 256'h5555,   256'h7777,   1, 1'b0, 256'hCE8E,           0, 1, 1};
        vecs[4] = '{1'b0, 2'b11, 256'h5555,   256'h7777,   0, 1'b0, 256'hECAC,           0, 1, 0};
        vecs[5] = '{1'b0, 2'b11, 256'h5555,   256'h7777,   1, 1'b0, 256'hCE8E,           0, 1, 0};
        vecs[6] = '{1'b0, 2'b01, top_bit,     256'h0,      0, 1'b0, top_bit ^ 256'hB9F9, 20, 0, 0};
        vecs[7] = '{1'b1, 2'b01, 256'h3,      256'h0,      0, 1'b0, 256'hB9FA,           0, 0, 0};
        vecs[8] = '{1'b1, 2'b10, 256'h0,      256'h5,      1, 1'b0, 256'hB9FC,           0, 0, 0};
        vecs[9] = '{1'b1, 2'b11, 256'h11,     256'h22,     0, 1'b0, 256'hB9E8,           0, 0, 0};

        rst_n = 1'b0; sel = 1'b0;
        t_req_valid = 2'b00; t_rsp_ready = 2'b00; t_op0 = '0; t_op1 = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        chk("reset_poly_a", a_inv_poly, 64'h0);
        chk("reset_busy_b", b_busy, 1'b0);
        chk("reset_poly_b", b_inv_poly, 64'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i], $sformatf("v%0d", i), wcnt);
        end

        // Reset while the counter holds 3: accept at T, count hits 3 at T+6.
        sel = 1'b0;
        t_req_valid = 2'b01; t_op0 = 256'h9; t_op1 = 256'h0;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (w_req_ready != 2'b00) begin got = 1; break; end
        end
        chk("rstw_accept", got, 1'b1);
        t_acc = cyc;
        t_req_valid = 2'b00;
        repeat (6) @(negedge clk);
        chk("rstw_in_wait", cyc - t_acc, 6);
        rst_n = 1'b0;
        @(negedge clk);
        chk_all_zero("rstw");
        rst_n = 1'b1;
        vr = '{1'b0, 2'b11, 256'h21, 256'h31, 0, 1'b0, 256'hB9D8, 0, 0, 0};
        run_txn(vr, "rst_tie", wcnt);
        chk("rst_tie_accept_delay", wcnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
